// File: rtl/ser_pkg.sv
// Shared serializer definitions: FSM state encoding, default word width and the
// bit-counter width helper used by the serializer and the downstream shift stage.
package ser_pkg;

  localparam int unsigned SER_WIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Wide enough for any frame index up to WIDTH (data bits plus an optional parity bit)
  function automatic int unsigned ser_cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/param_bit_counter.sv
// Frame bit counter: synchronous clear-to-zero, count enable, and a terminal-count
// flag raised when the count equals a programmable last index.
module param_bit_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [CW-1:0] i_term,
  output logic [CW-1:0] o_count,
  output logic          o_tc_c
);

  logic [CW-1:0] r_count;

  // Holds at the terminal value so the count never runs past the frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en && !o_tc_c) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc_c  = (r_count == i_term);

endmodule

// File: rtl/param_piso_ser.sv
// Parallel-in/serial-out serializer with valid/ready word input and bit_valid/last_bit
// framing. Define PISO_PARITY_EN to append an even-parity bit to every frame.
module param_piso_ser
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             last_bit
);

  localparam int unsigned CW = ser_cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shadow;
  logic             r_data_out;
  logic             r_bit_valid;
  logic             r_last_bit;

  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_next_idx;
  logic             w_tc;
  logic             w_accept;
  logic             w_load;
  logic             w_en;

  // Data bit at frame position k in the configured bit order
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
    logic [WIDTH-1:0] v;
    if (MSB_FIRST) begin
      v = w << k;
      return v[WIDTH-1];
    end else begin
      v = w >> k;
      return v[0];
    end
  endfunction

  assign din_ready  = (r_state == ST_IDLE) || r_last_bit;
  assign w_accept   = din_valid && din_ready;
  assign w_next_idx = w_count + CW'(1);
  assign w_en       = (r_state == ST_SHIFT);
  assign w_load     = w_accept || ((r_state == ST_SHIFT) && w_tc);

  param_bit_counter #(
    .CW(CW)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_en),
    .i_term (LAST_IDX),
    .o_count(w_count),
    .o_tc_c (w_tc)
  );

  // An accept (idle or on the last bit) always wins, so back-to-back frames have no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_data_out  <= 1'b0;
      r_bit_valid <= 1'b0;
      r_last_bit  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_SHIFT;
      r_shadow    <= din;
      r_data_out  <= pick(din, '0);
      r_bit_valid <= 1'b1;
      r_last_bit  <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (r_last_bit) begin
        r_state     <= ST_IDLE;
        r_data_out  <= 1'b0;
        r_bit_valid <= 1'b0;
        r_last_bit  <= 1'b0;
      end else begin
`ifdef PISO_PARITY_EN
        if (w_next_idx == CW'(WIDTH)) begin
          r_data_out <= ^r_shadow;
        end else begin
          r_data_out <= pick(r_shadow, w_next_idx);
        end
`else
        r_data_out <= pick(r_shadow, w_next_idx);
`endif
        r_last_bit <= (w_next_idx == LAST_IDX);
      end
    end
  end

  assign data_out  = r_data_out;
  assign bit_valid = r_bit_valid;
  assign last_bit  = r_last_bit;

endmodule

// File: tb/tb_param_piso_ser.sv
// Bench for param_piso_ser: MSB-first and LSB-first instances checked every cycle
// against a frame-queue model, plus hand-computed word, timing and loopback checks.
module tb_param_piso_ser;
  import ser_pkg::*;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_a  [2];
  logic         vld_a  [2];
  logic         dout_a [2];
  logic         bv_a   [2];
  logic         lb_a   [2];
  logic         rdy_a  [2];

  always #5 clk = ~clk;

  param_piso_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(vld_a[0]), .din_ready(rdy_a[0]),
    .data_out(dout_a[0]), .bit_valid(bv_a[0]), .last_bit(lb_a[0])
  );

  param_piso_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(vld_a[1]), .din_ready(rdy_a[1]),
    .data_out(dout_a[1]), .bit_valid(bv_a[1]), .last_bit(lb_a[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: each accepted word expands into a queue of (bit, last) entries, one popped per clock
  int   q [2][$];
  logic cur_v [2];
  logic cur_b [2];
  logic cur_l [2];

  function automatic logic exp_ready(input int i);
    return !cur_v[i] || cur_l[i];
  endfunction

  task automatic push_frame(input int i, input logic [W-1:0] w);
    logic b;
    for (int k = 0; k < int'(FL); k++) begin
      if (k >= int'(W))  b = ^w;
      else if (i == 0)   b = w[int'(W) - 1 - k];
      else               b = w[k];
      q[i].push_back(int'(b) + ((k == int'(FL) - 1) ? 2 : 0));
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        q[i].delete();
        cur_v[i] = 1'b0; cur_b[i] = 1'b0; cur_l[i] = 1'b0;
      end else begin
        if (vld_a[i] && exp_ready(i)) push_frame(i, din_a[i]);
        if (q[i].size() > 0) begin
          int e;
          e = q[i].pop_front();
          cur_v[i] = 1'b1;
          cur_b[i] = e[0];
          cur_l[i] = e[1];
        end else begin
          cur_v[i] = 1'b0; cur_b[i] = 1'b0; cur_l[i] = 1'b0;
        end
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("bit_valid[%0d]", i), 32'(bv_a[i]),   32'(cur_v[i]));
        chk($sformatf("data_out[%0d]", i),  32'(dout_a[i]), 32'(cur_v[i] ? cur_b[i] : 1'b0));
        chk($sformatf("last_bit[%0d]", i),  32'(lb_a[i]),   32'(cur_l[i]));
        chk($sformatf("din_ready[%0d]", i), 32'(rdy_a[i]),  32'(exp_ready(i)));
      end
    end
  end

  // Collect complete frames as seen on the serial outputs
  logic [FL-1:0] acc [2];
  int            acnt [2];
  int            rx_d [2][$];
  int            rx_p [2][$];
  logic [W-1:0]  d_tmp;

  initial begin
    acnt[0] = 0; acnt[1] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bv_a[i] === 1'b1) begin
        if (acnt[i] < int'(FL)) acc[i][acnt[i]] = dout_a[i];
        acnt[i]++;
        if (lb_a[i] === 1'b1) begin
          for (int j = 0; j < int'(W); j++) begin
            if (i == 0) d_tmp[int'(W) - 1 - j] = acc[i][j];
            else        d_tmp[j] = acc[i][j];
          end
          rx_d[i].push_back(int'(d_tmp));
          rx_p[i].push_back(int'(acc[i][FL-1]));
          acnt[i] = 0;
        end
      end else begin
        acnt[i] = 0;
      end
    end
  end

  // Behavioural downstream shift register fed MSB-first
  logic [W-1:0] sr;
  always @(posedge clk) begin
    if (rst)           sr <= '0;
    else if (bv_a[0])  sr <= {sr[W-2:0], dout_a[0]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int g;
    g = 0;
    while (bv_a[i] && g < 60) begin
      step();
      g++;
    end
    chk($sformatf("idle_reached[%0d]", i), 32'(bv_a[i]), 32'd0);
  endtask

  task automatic send_word(input int i, input logic [W-1:0] w);
    din_a[i] = w;
    vld_a[i] = 1'b1;
    step();
    vld_a[i] = 1'b0;
    wait_idle(i);
  endtask

  int exp0 [7] = '{8'hA5, 8'hA5, 8'h3C, 8'h81, 8'hA5, 8'h00, 8'h07};
  int exp1 [2] = '{8'h01, 8'hB2};

  initial begin
    int n;
    int g;
    rst = 1'b1;
    vld_a[0] = 1'b0; vld_a[1] = 1'b0;
    din_a[0] = '0;   din_a[1] = '0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_ready", 32'(rdy_a[0]), 32'd1);
    chk("reset_bit_valid", 32'(bv_a[0]), 32'd0);
    chk("reset_data_out", 32'(dout_a[0]), 32'd0);
    rst = 1'b0;
    step();

    // Single MSB-first frame
    din_a[0] = 8'hA5; vld_a[0] = 1'b1;
    step();
    vld_a[0] = 1'b0;
    chk("a_first_valid", 32'(bv_a[0]), 32'd1);
    chk("a_first_bit", 32'(dout_a[0]), 32'd1);
    chk("a_ready_busy", 32'(rdy_a[0]), 32'd0);
    n = 1; g = 0;
    while (!lb_a[0] && g < 40) begin
      step();
      if (bv_a[0]) n++;
      g++;
    end
    chk("a_frame_len", 32'(n), 32'(FL));
    step();
`ifndef PISO_PARITY_EN
    chk("loopback_sr", 32'(sr), 32'h0000_00A5);
`endif
    chk("a_idle_after", 32'(bv_a[0]), 32'd0);
    step();

    // Back-to-back: valid held, second word waits for the last-bit cycle
    din_a[0] = 8'hA5; vld_a[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bv_a[0]) n++;
      if (n == 1) din_a[0] = 8'h3C;
      if (n == int'(FL) + 1) vld_a[0] = 1'b0;
      if (!bv_a[0] && n > 0) break;
    end
    vld_a[0] = 1'b0;
    chk("b2b_contig", 32'(n), 32'(2 * FL));
    step();

    // Mid-frame reset drops the partial word
    din_a[0] = 8'hFF; vld_a[0] = 1'b1;
    step();
    vld_a[0] = 1'b0;
    n = 1; g = 0;
    while (n < 3 && g < 20) begin
      step();
      if (bv_a[0]) n++;
      g++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_bit_valid", 32'(bv_a[0]), 32'd0);
    chk("mr_data_out", 32'(dout_a[0]), 32'd0);
    chk("mr_ready", 32'(rdy_a[0]), 32'd1);
    step();
    send_word(0, 8'h81);
    step();

    // Input changes while busy are ignored until the last-bit edge
    din_a[0] = 8'hA5; vld_a[0] = 1'b1;
    step();
    din_a[0] = 8'h00;
    g = 0;
    while (!lb_a[0] && g < 40) begin
      step();
      g++;
    end
    step();
    vld_a[0] = 1'b0;
    chk("ign_next_valid", 32'(bv_a[0]), 32'd1);
    chk("ign_next_bit", 32'(dout_a[0]), 32'd0);
    wait_idle(0);
    step();

    send_word(0, 8'h07);
    step();

    // LSB-first instance
    send_word(1, 8'h01);
    step();
    send_word(1, 8'hB2);
    step();
    step();

    chk("rx0_count", 32'(rx_d[0].size()), 32'd7);
    for (int k = 0; k < 7 && k < rx_d[0].size(); k++)
      chk($sformatf("rx0_word%0d", k), 32'(rx_d[0][k]), 32'(exp0[k]));
    chk("rx1_count", 32'(rx_d[1].size()), 32'd2);
    for (int k = 0; k < 2 && k < rx_d[1].size(); k++)
      chk($sformatf("rx1_word%0d", k), 32'(rx_d[1][k]), 32'(exp1[k]));
`ifdef PISO_PARITY_EN
    if (rx_p[0].size() == 7) begin
      chk("parity_A5", 32'(rx_p[0][0]), 32'd0);
      chk("parity_07", 32'(rx_p[0][6]), 32'd1);
    end else begin
      chk("parity_count", 32'(rx_p[0].size()), 32'd7);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
